vdp_cpu_port: RTL and testbench

CPU-side access engine for the VDP's VRAM. It decodes Z80 writes and reads on the VDP control and data ports into single-cycle accesses on one port of the VRAM dual-port RAM. Each RAM port has a registered read with one cycle of latency, and the engine's prefetch read buffer hides that latency from the CPU. It sits between the Z80 I/O decode and port A of the VRAM; the VDP renderer owns port B. It also emits register writes and CRAM writes.

---
 rtl/vdp_pkg.sv | 8 +
 rtl/vdp_cpu_port.sv | 153 +++++++++++++++
 tb/tb_vdp_cpu_port.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/vdp_pkg.sv
// vdp_pkg: shared state encoding and access-code constants for the VDP CPU port
package vdp_pkg;
  typedef enum logic [1:0] {IDLE, WR, RD_ISSUE, RD_WAIT} state_t;
  localparam logic [1:0] CODE_VRD  = 2'd0;
  localparam logic [1:0] CODE_VWR  = 2'd1;
  localparam logic [1:0] CODE_REG  = 2'd2;
  localparam logic [1:0] CODE_CRAM = 2'd3;
endpackage

// File: rtl/vdp_cpu_port.sv
// vdp_cpu_port: decodes Z80 control/data port accesses into VRAM, register and CRAM accesses
module vdp_cpu_port
  import vdp_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int CRAM_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  input  logic              cpu_a0,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data_w,
  output logic              ram_wren,
  input  logic [7:0]        ram_q,
  output logic              reg_wren,
  output logic [3:0]        reg_num,
  output logic [7:0]        reg_data,
  output logic              cram_wren,
  output logic [CRAM_W-1:0] cram_addr,
  output logic [7:0]        cram_data
);
  state_t              r_state, w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [1:0]          r_code;
  logic [7:0]          r_latch;
  logic                r_first;
  logic [7:0]          r_rdbuf;
  logic                r_busy;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [7:0]          r_ram_data_w;
  logic                r_ram_wren;
  logic                r_reg_wren;
  logic [3:0]          r_reg_num;
  logic [7:0]          r_reg_data;
  logic                r_cram_wren;
  logic [CRAM_W-1:0]   r_cram_addr;
  logic [7:0]          r_cram_data;
  logic                w_idle, w_cw_lo, w_cw_hi, w_cr, w_dw, w_dr;
  logic                w_vwr, w_cwr, w_reg, w_pref;
  logic [ADDR_W-1:0]   w_addr_lo, w_addr_set, w_addr_inc;

  assign cpu_dout   = r_rdbuf;
  assign busy       = r_busy;
  assign ram_addr   = r_ram_addr;
  assign ram_data_w = r_ram_data_w;
  assign ram_wren   = r_ram_wren;
  assign reg_wren   = r_reg_wren;
  assign reg_num    = r_reg_num;
  assign reg_data   = r_reg_data;
  assign cram_wren  = r_cram_wren;
  assign cram_addr  = r_cram_addr;
  assign cram_data  = r_cram_data;

  // Strobe decode: only sampled in IDLE, and a write beats a simultaneous read
  always_comb begin
    w_idle     = r_state == IDLE;
    w_cw_lo    = w_idle & cpu_wr & cpu_a0 & ~r_first;
    w_cw_hi    = w_idle & cpu_wr & cpu_a0 & r_first;
    w_cr       = w_idle & ~cpu_wr & cpu_rd & cpu_a0;
    w_dw       = w_idle & cpu_wr & ~cpu_a0;
    w_dr       = w_idle & ~cpu_wr & cpu_rd & ~cpu_a0;
    w_vwr      = w_dw & (r_code != CODE_CRAM);
    w_cwr      = w_dw & (r_code == CODE_CRAM);
    w_reg      = w_cw_hi & (cpu_din[7:6] == CODE_REG);
    w_pref     = (w_cw_hi & (cpu_din[7:6] == CODE_VRD)) | w_dr;
    w_addr_lo  = {r_addr[ADDR_W-1:8], cpu_din};
    w_addr_set = ADDR_W'({cpu_din[5:0], r_addr[7:0]});
    w_addr_inc = r_addr + ADDR_W'(1);
  end

  // Next-state logic: writes take one busy cycle, prefetches two
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = w_vwr ? WR : w_pref ? RD_ISSUE : IDLE;
      WR:       w_next = IDLE;
      RD_ISSUE: w_next = RD_WAIT;
      RD_WAIT:  w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Datapath: address counter, latch/flag, read buffer and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr       <= '0;
      r_code       <= '0;
      r_latch      <= '0;
      r_first      <= 1'b0;
      r_rdbuf      <= '0;
      r_busy       <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_data_w <= '0;
      r_ram_wren   <= 1'b0;
      r_reg_wren   <= 1'b0;
      r_reg_num    <= '0;
      r_reg_data   <= '0;
      r_cram_wren  <= 1'b0;
      r_cram_addr  <= '0;
      r_cram_data  <= '0;
    end else begin
      r_busy      <= w_next != IDLE;
      r_ram_wren  <= w_vwr;
      r_reg_wren  <= w_reg;
      r_cram_wren <= w_cwr;
      if (w_cw_lo) begin
        r_latch <= cpu_din;
        r_addr  <= w_addr_lo;
        r_first <= 1'b1;
      end
      if (w_cw_hi) begin
        r_code  <= cpu_din[7:6];
        r_addr  <= w_addr_set;
        r_first <= 1'b0;
      end
      if (w_reg) begin
        r_reg_num  <= cpu_din[3:0];
        r_reg_data <= r_latch;
      end
      if (w_cr | w_dr) r_first <= 1'b0;
      if (w_dw) begin
        r_first <= 1'b0;
        r_rdbuf <= cpu_din;
      end
      if (w_vwr) begin
        r_ram_addr   <= r_addr;
        r_ram_data_w <= cpu_din;
      end
      if (w_cwr) begin
        r_cram_addr <= r_addr[CRAM_W-1:0];
        r_cram_data <= cpu_din;
        r_addr      <= w_addr_inc;
      end
      if (w_pref) r_ram_addr <= w_cw_hi ? w_addr_set : r_addr;
      if (r_state == WR) r_addr <= w_addr_inc;
      if (r_state == RD_WAIT) begin
        r_rdbuf <= ram_q;
        r_addr  <= w_addr_inc;
      end
    end
  end
endmodule

// File: tb/tb_vdp_cpu_port.sv
// tb_vdp_cpu_port: transaction-level model of the CPU port checked against the DUT every cycle
module tb_vdp_cpu_port;
  localparam int K_NONE = 0, K_WR = 1, K_PF = 2, K_REG = 3, K_CRAM = 4;
  logic        clk = 0, reset = 1, cpu_wr = 0, cpu_rd = 0, cpu_a0 = 0;
  logic [7:0]  cpu_din = 0, cpu_dout, ram_data_w, ram_q, reg_data, cram_data;
  logic        busy, ram_wren, reg_wren, cram_wren;
  logic [13:0] ram_addr;
  logic [3:0]  reg_num;
  logic [4:0]  cram_addr;
  vdp_cpu_port dut (
    .clk(clk), .reset(reset), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_a0(cpu_a0),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .busy(busy), .ram_addr(ram_addr),
    .ram_data_w(ram_data_w), .ram_wren(ram_wren), .ram_q(ram_q), .reg_wren(reg_wren),
    .reg_num(reg_num), .reg_data(reg_data), .cram_wren(cram_wren),
    .cram_addr(cram_addr), .cram_data(cram_data)
  );
  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input int i);
    return (i == 'h1234) ? 8'hAB : (i[7:0] ^ 8'hA5);
  endfunction

  logic [7:0] mem [0:16383];
  logic       mem_ready = 0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 16384; i++) mem[i] <= pat(i);
      mem_ready <= 1;
    end else if (ram_wren) mem[ram_addr] <= ram_data_w;
    ram_q <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, e);
    end
  endtask

  logic [7:0]  vm [0:16383];
  logic [13:0] m_addr = 0;
  logic [1:0]  m_code = 0;
  logic [7:0]  m_latch = 0, m_rdbuf = 0, e_data = 0;
  logic        m_first = 0, chk_en = 0;
  logic [13:0] e_addr = 0;
  logic [3:0]  e_num = 0;
  int          k = K_NONE, t_cyc = 0;
  int          wren_cnt = 0, reg_cnt = 0, cram_cnt = 0;
  logic [13:0] last_wr_addr = 0;
  logic [3:0]  last_reg_num = 0;
  logic [7:0]  last_reg_data = 0, last_cram_data = 0;
  logic [4:0]  last_cram_addr = 0;

  int   d;
  logic eb, ew;
  always @(negedge clk) begin
    if (ram_wren) begin wren_cnt++; last_wr_addr = ram_addr; end
    if (reg_wren) begin reg_cnt++; last_reg_num = reg_num; last_reg_data = reg_data; end
    if (cram_wren) begin cram_cnt++; last_cram_addr = cram_addr; last_cram_data = cram_data; end
    if (chk_en) begin
      d  = cyc - t_cyc;
      ew = (k == K_WR) && (d == 0);
      eb = ew || ((k == K_PF) && (d <= 1));
      chk("busy", busy, eb);
      chk("ram_wren", ram_wren, ew);
      chk("reg_wren", reg_wren, (k == K_REG) && (d == 0));
      chk("cram_wren", cram_wren, (k == K_CRAM) && (d == 0));
      if (!eb) chk("cpu_dout", cpu_dout, m_rdbuf);
      if (ew) begin
        chk("wr_addr", ram_addr, e_addr);
        chk("wr_data", ram_data_w, e_data);
      end
      if (k == K_PF && d == 0) chk("rd_addr", ram_addr, e_addr);
      if (k == K_REG && d == 0) begin
        chk("reg_num", reg_num, e_num);
        chk("reg_data", reg_data, e_data);
      end
      if (k == K_CRAM && d == 0) begin
        chk("cram_addr", cram_addr, e_addr[4:0]);
        chk("cram_data", cram_data, e_data);
      end
    end
  end

  task automatic strobe(input logic wr, input logic rd, input logic a0, input logic [7:0] din);
    @(posedge clk); #2;
    cpu_wr = wr; cpu_rd = rd; cpu_a0 = a0; cpu_din = din;
    @(posedge clk); #1;
    cpu_wr = 0; cpu_rd = 0;
    t_cyc = cyc; k = K_NONE;
  endtask
  task automatic gap; repeat (4) @(posedge clk); endtask
  task automatic mpref;
    k = K_PF; e_addr = m_addr; m_rdbuf = vm[m_addr]; m_addr = m_addr + 1;
  endtask
  task automatic ctrl_wr(input logic [7:0] din);
    strobe(1, 0, 1, din);
    if (!m_first) begin
      m_latch = din; m_addr[7:0] = din; m_first = 1;
    end else begin
      m_code = din[7:6]; m_addr[13:8] = din[5:0]; m_first = 0;
      if (m_code == 2'd0) mpref;
      else if (m_code == 2'd2) begin k = K_REG; e_num = din[3:0]; e_data = m_latch; end
    end
    gap;
  endtask
  task automatic ctrl_rd;
    strobe(0, 1, 1, 0); m_first = 0; gap;
  endtask
  task automatic data_wr(input logic [7:0] din, input logic also_rd);
    strobe(1, also_rd, 0, din);
    m_first = 0; m_rdbuf = din; e_addr = m_addr; e_data = din;
    if (m_code == 2'd3) k = K_CRAM;
    else begin k = K_WR; vm[m_addr] = din; end
    m_addr = m_addr + 1;
    gap;
  endtask
  task automatic data_rd(input logic with_gap);
    strobe(0, 1, 0, 0); m_first = 0; mpref;
    if (with_gap) gap;
  endtask

  int w0;
  initial begin
    for (int i = 0; i < 16384; i++) vm[i] = pat(i);
    repeat (3) @(posedge clk);
    #2;
    chk("rst_dout", cpu_dout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_outs", {ram_wren, reg_wren, cram_wren, ram_addr, ram_data_w}, 0);
    chk("rst_outs2", {reg_num, reg_data, cram_addr, cram_data}, 0);
    @(posedge clk); #1; reset = 0; t_cyc = cyc; chk_en = 1;
    gap;
    // address setup and prefetch
    ctrl_wr(8'h34); ctrl_wr(8'h12);
    chk("t1_dout", cpu_dout, 8'hAB);
    data_wr(8'h77, 0);
    chk("t1_next_addr", last_wr_addr, 14'h1235);
    // write run with wrap
    ctrl_wr(8'hFF); ctrl_wr(8'h7F);
    w0 = wren_cnt;
    data_wr(8'h11, 0); data_wr(8'h22, 0);
    chk("t2_mem3fff", mem[14'h3FFF], 8'h11);
    chk("t2_mem0", mem[0], 8'h22);
    chk("t2_wren_cycles", wren_cnt - w0, 2);
    // register write
    ctrl_wr(8'h80); ctrl_wr(8'h81);
    chk("t3_reg_cnt", reg_cnt, 1);
    chk("t3_reg", {last_reg_num, last_reg_data}, {4'h1, 8'h80});
    // cram write
    w0 = wren_cnt;
    ctrl_wr(8'h05); ctrl_wr(8'hC0); data_wr(8'h3F, 0);
    chk("t4_cram", {cram_cnt[3:0], 3'b0, last_cram_addr, last_cram_data}, {4'd1, 3'b0, 5'd5, 8'h3F});
    chk("t4_no_vram", wren_cnt - w0, 0);
    // control read clears the first flag
    ctrl_wr(8'h34); ctrl_rd; ctrl_wr(8'h12); ctrl_wr(8'h40);
    data_wr(8'h5A, 0);
    chk("t5_flag_clear", last_wr_addr, 14'h0012);
    // strobe while busy is ignored
    ctrl_wr(8'h00); ctrl_wr(8'h00);
    chk("t6_pref0", cpu_dout, 8'h22);
    w0 = wren_cnt;
    data_rd(0);
    #1; cpu_wr = 1; cpu_a0 = 0; cpu_din = 8'h99;
    @(posedge clk); #1; cpu_wr = 0;
    gap;
    chk("t6_ignored", wren_cnt - w0, 0);
    chk("t6_dout", cpu_dout, pat(1));
    data_wr(8'h44, 0);
    chk("t6_addr", last_wr_addr, 14'h0002);
    // write and read together
    data_wr(8'h66, 1);
    chk("t7_mem", mem[3], 8'h66);
    chk("t7_dout", cpu_dout, 8'h66);
    // reset mid-prefetch
    chk_en = 0; w0 = wren_cnt;
    strobe(0, 1, 0, 0);
    @(posedge clk); #2;
    reset = 1; #1;
    chk("t8_busy", busy, 0);
    chk("t8_dout", cpu_dout, 0);
    chk("t8_wren", ram_wren, 0);
    chk("t8_ram_addr", ram_addr, 0);
    repeat (2) @(posedge clk); #1;
    reset = 0;
    m_addr = 0; m_code = 0; m_latch = 0; m_rdbuf = 0; m_first = 0;
    t_cyc = cyc; k = K_NONE; chk_en = 1;
    gap;
    chk("t8_no_write", wren_cnt - w0, 0);
    data_wr(8'h55, 0);
    chk("t8_addr0", last_wr_addr, 0);
    chk("t8_mem0", mem[0], 8'h55);
    gap;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "timeout");
  end
endmodule
